// File: rtl/processador_param_pkg.sv
// processador_param_pkg: opcodes, FSM states and sizing helper shared by the multicycle core
package processador_param_pkg;
  localparam logic [3:0] OP_MV   = 4'h0;
  localparam logic [3:0] OP_MVI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_MVNZ = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EX1, EX2} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/banco_registradores_param.sv
// banco_registradores_param: NREGS x DATA_W register file whose top entry doubles as the PC
module banco_registradores_param #(
  parameter int DATA_W = 16,
  parameter int NREGS = 8,
  parameter int RSEL_W = 3,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              pc_inc_i,
  input  logic [RSEL_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RSEL_W-1:0] rx_sel_i,
  input  logic [RSEL_W-1:0] ry_sel_i,
  output logic [DATA_W-1:0] rx_o,
  output logic [DATA_W-1:0] ry_o,
  output logic [DATA_W-1:0] pc_o
);
  logic [DATA_W-1:0] r_q [NREGS];
  // the explicit write is issued after the increment so it wins when both target the PC
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_q[i] <= '0;
      r_q[NREGS-1] <= RESET_PC;
    end else begin
      if (pc_inc_i) r_q[NREGS-1] <= r_q[NREGS-1] + DATA_W'(1);
      if (we_i) r_q[waddr_i] <= wdata_i;
    end
  end
  assign rx_o = r_q[rx_sel_i];
  assign ry_o = r_q[ry_sel_i];
  assign pc_o = r_q[NREGS-1];
endmodule

// File: rtl/processador_multiciclo_param.sv
// processador_multiciclo_param: parametrised multicycle core with a single req/ack memory port
module processador_multiciclo_param
  import processador_param_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS = 8,
  parameter int ADDR_W = 6,
  parameter int RESET_PC = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              Done,
  output logic              Err,
  output logic              Zflag,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] Rx_data,
  output logic [DATA_W-1:0] Ry_data
);
  localparam int RSEL_W = clog2(NREGS);
  localparam int IR_W = 4 + 2 * RSEL_W;
  state_t state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, g_q, g_d, alu_y, rf_wdata;
  logic zflag_q, z_d, is_alu, ack, rf_we, pc_inc;
  logic [3:0] op;
  logic [RSEL_W-1:0] rx, ry;
  assign {op, rx, ry} = ir_q;
  assign is_alu = op inside {OP_ADD, OP_SUB, OP_AND};
  assign Zflag = zflag_q;
  banco_registradores_param #(
    .DATA_W(DATA_W), .NREGS(NREGS), .RSEL_W(RSEL_W), .RESET_PC(DATA_W'(RESET_PC))
  ) u_rf (
    .clk(Clock), .rst(Reset), .we_i(rf_we), .pc_inc_i(pc_inc), .waddr_i(rx), .wdata_i(rf_wdata),
    .rx_sel_i(rx), .ry_sel_i(ry), .rx_o(Rx_data), .ry_o(Ry_data), .pc_o(pc)
  );
  // state register
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // sequencing: a fetched instruction always completes, Run only gates the next fetch
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = Run ? FETCH : IDLE;
      FETCH:   state_d = ack ? DECODE : FETCH;
      DECODE:  state_d = EX1;
      EX1:     state_d = is_alu ? EX2 : Done ? (Run ? FETCH : IDLE) : EX1;
      EX2:     state_d = Run ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // memory port, completion pulses and register-file control decoded from state and opcode
  always_comb begin
    mem_req = state_q == FETCH || (state_q == EX1 && op inside {OP_MVI, OP_LD, OP_ST});
    mem_we = state_q == EX1 && op == OP_ST;
    mem_addr = (state_q == FETCH || op == OP_MVI) ? pc[ADDR_W-1:0] : Ry_data[ADDR_W-1:0];
    mem_wdata = Rx_data;
    ack = mem_req && mem_ack;
    Err = state_q == EX1 && op[3];
    Done = state_q == EX2 || (state_q == EX1 && (op inside {OP_MV, OP_MVNZ} || op[3] || ack));
    pc_inc = ack && (state_q == FETCH || op == OP_MVI);
    rf_we = state_q == EX2 || (state_q == EX1 && (op == OP_MV || (op == OP_MVNZ && !zflag_q) || (ack && op != OP_ST)));
    rf_wdata = state_q == EX2 ? g_q : (op inside {OP_MV, OP_MVNZ}) ? Ry_data : mem_rdata;
  end
  // datapath next values; sub is A + ~B + 1 so the adder is shared
  always_comb begin
    alu_y = op == OP_AND ? (a_q & Ry_data) : a_q + (op == OP_SUB ? ~Ry_data : Ry_data) + DATA_W'(op == OP_SUB);
    ir_d = (state_q == FETCH && ack) ? mem_rdata[IR_W-1:0] : ir_q;
    a_d = state_q == DECODE ? Rx_data : a_q;
    g_d = (state_q == EX1 && is_alu) ? alu_y : g_q;
    z_d = (state_q == EX1 && is_alu) ? (alu_y == '0) : zflag_q;
  end
  // datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ir_q <= '0;
      a_q <= '0;
      g_q <= '0;
      zflag_q <= 1'b0;
    end else begin
      ir_q <= ir_d;
      a_q <= a_d;
      g_q <= g_d;
      zflag_q <= z_d;
    end
  end
endmodule

// File: tb/tb_processador_multiciclo_param.sv
// tb_processador_multiciclo_param: ISA-level reference model against the core with a random-latency memory
module tb_processador_multiciclo_param;
  logic clk = 1'b0, Reset = 1'b1, Run = 1'b0, mem_ack = 1'b0;
  logic mem_req, mem_we, Done, Err, Zflag;
  logic [5:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata = '0, pc, Rx_data, Ry_data;
  logic [15:0] mem [64];
  logic [15:0] mmem [64];
  logic [15:0] mreg [8];
  logic mz, me, t_we;
  logic [5:0] t_addr, wr_addr, msa;
  logic [15:0] t_wdata, wr_data, msd;
  int n_chk, n_fail, cnt, waits, nwr, done_cnt, err_cnt, wait_fixed, wleft, prx, pry, mb, mns;
  bit chk_en, idle, busy, post_pend, dn;

  processador_multiciclo_param dut (
    .Clock(clk), .Reset(Reset), .Run(Run), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Done(Done), .Err(Err),
    .Zflag(Zflag), .pc(pc), .Rx_data(Rx_data), .Ry_data(Ry_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(logic [3:0] op, logic [2:0] x, logic [2:0] y);
    return {6'b0, op, x, y};
  endfunction

  // one instruction at ISA level: R[7] is the PC, memory indexed by the low 6 address bits
  task automatic model_step(output logic err, output int base, output int nst, output logic [5:0] sa,
                            output logic [15:0] sd, output int rx, output int ry);
    logic [15:0] ins, a, b, r, imm;
    int op;
    ins = mmem[mreg[7][5:0]];
    mreg[7] += 16'd1;
    op = int'(ins[9:6]);
    rx = int'(ins[5:3]);
    ry = int'(ins[2:0]);
    a = mreg[rx];
    b = mreg[ry];
    err = 1'b0; base = 3; nst = 0; sa = '0; sd = '0;
    case (op)
      0: mreg[rx] = b;
      1: begin imm = mmem[mreg[7][5:0]]; mreg[7] += 16'd1; mreg[rx] = imm; end
      2, 3, 7: begin
        r = op == 2 ? a + b : op == 3 ? a - b : a & b;
        mz = (r == 16'd0);
        mreg[rx] = r;
        base = 4;
      end
      4: mreg[rx] = mmem[b[5:0]];
      5: begin mmem[b[5:0]] = a; nst = 1; sa = b[5:0]; sd = a; end
      6: if (!mz) mreg[rx] = b;
      default: err = 1'b1;
    endcase
  endtask

  // memory responder plus per-instruction comparison against the model
  initial forever begin
    @(negedge clk);
    if (Reset || !mem_req) begin
      busy = 0;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
    end else begin
      if (!busy) begin
        busy = 1;
        wleft = wait_fixed >= 0 ? wait_fixed : int'($urandom_range(0, 3));
        waits += wleft;
        t_addr = mem_addr; t_we = mem_we; t_wdata = mem_wdata;
      end else begin
        chk("hs_addr", mem_addr, t_addr);
        chk("hs_we", mem_we, t_we);
        if (t_we) chk("hs_wdata", mem_wdata, t_wdata);
      end
      if (wleft == 0) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) begin mem[mem_addr] = mem_wdata; nwr++; wr_addr = mem_addr; wr_data = mem_wdata; end
        busy = 0;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
        wleft--;
      end
    end
    #1;
    if (chk_en) begin
      if (post_pend) begin
        chk("pc", pc, mreg[7]);
        chk("zflag", Zflag, mz);
        chk("rx_data", Rx_data, mreg[prx]);
        chk("ry_data", Ry_data, mreg[pry]);
        post_pend = 0;
      end
      if (idle) chk("idle_quiet", {mem_req, Done}, 2'b00);
      else begin
        cnt++;
        if (Done) begin
          model_step(me, mb, mns, msa, msd, prx, pry);
          chk("err", Err, me);
          chk("latency", cnt, mb + waits);
          chk("stores", nwr, mns);
          if (mns != 0) begin chk("st_addr", wr_addr, msa); chk("st_data", wr_data, msd); end
          err_cnt += int'(Err);
          cnt = 0; waits = 0; nwr = 0;
          done_cnt++;
          post_pend = 1;
          dn = 1;
        end else chk("err_without_done", Err, 1'b0);
      end
    end
    #2;
    if (idle && Run) idle = 0;
    else if (dn && !Run) idle = 1;
    dn = 0;
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
  endtask

  task automatic fill_rand();
    int op;
    for (int i = 0; i < 64; i++) begin
      op = int'($urandom_range(0, 8));
      if (op == 8) op = int'($urandom_range(8, 15));
      mem[i] = {6'($urandom), 4'(op), 6'($urandom)};
    end
  endtask

  // reset, run until n instructions complete (optionally toggling Run), then park in IDLE
  task automatic run_prog(int n, int wf, bit rr);
    wait_fixed = wf; chk_en = 0; Reset = 1; Run = 0;
    repeat (2) @(negedge clk);
    #2;
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
    mz = 0; mmem = mem;
    cnt = 0; waits = 0; nwr = 0; done_cnt = 0; err_cnt = 0; post_pend = 0; idle = 1;
    Reset = 0; Run = 1; chk_en = 1;
    for (int c = 0; c < 20000 && done_cnt < n; c++) begin
      @(negedge clk);
      #2;
      if (done_cnt >= n) Run = 0;
      else if (rr) Run = $urandom_range(0, 7) != 0;
    end
    Run = 0;
    chk("instr_count", done_cnt, n);
    repeat (4) @(negedge clk);
    #4;
  endtask

  initial begin
    clear_mem();
    mem[0] = enc(1, 0, 0); mem[1] = 16'd5; mem[2] = enc(1, 1, 0); mem[3] = 16'd3; mem[4] = enc(2, 0, 1);
    run_prog(3, 0, 0);
    chk("p1_r0", Rx_data, 16'd8);
    chk("p1_r1", Ry_data, 16'd3);
    chk("p1_z", Zflag, 1'b0);
    chk("p1_pc", pc, 16'd5);

    chk_en = 0; wait_fixed = 10;
    @(negedge clk);
    #2 Run = 1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_pre_req", mem_req, 1'b1);
    Reset = 1; Run = 0;
    @(negedge clk);
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_pc", pc, 16'd0);
    chk("rst_rx", Rx_data, 16'd0);
    chk("rst_ry", Ry_data, 16'd0);
    chk("rst_done", {Done, Err, Zflag}, 3'b000);
    #1 Reset = 0;
    repeat (3) @(negedge clk);
    #1 chk("rst_idle_req", mem_req, 1'b0);

    clear_mem();
    mem[0] = enc(1, 1, 0); mem[1] = 16'd3; mem[2] = enc(3, 0, 0); mem[3] = enc(6, 2, 1);
    mem[4] = enc(2, 1, 1); mem[5] = enc(6, 2, 1);
    run_prog(3, 0, 0);
    chk("p2_r2_kept", Rx_data, 16'd0);
    chk("p2_z_set", Zflag, 1'b1);
    run_prog(5, 0, 0);
    chk("p2_r2_moved", Rx_data, 16'd6);
    chk("p2_r1", Ry_data, 16'd6);
    chk("p2_z_clr", Zflag, 1'b0);

    clear_mem();
    mem[0] = enc(1, 3, 0); mem[1] = 16'd10; mem[2] = enc(1, 1, 0); mem[3] = 16'h1234;
    mem[4] = enc(5, 1, 3); mem[5] = enc(4, 4, 3);
    run_prog(4, 3, 0);
    chk("p3_mem10", mem[10], 16'h1234);
    chk("p3_r4", Rx_data, 16'h1234);
    chk("p3_r3", Ry_data, 16'd10);

    clear_mem();
    mem[0] = enc(1, 5, 0); mem[1] = 16'hFFFF; mem[2] = enc(1, 6, 0); mem[3] = 16'd1;
    mem[4] = enc(2, 5, 6); mem[5] = enc(1, 7, 0); mem[6] = 16'hFFFF; mem[63] = enc(0, 0, 5);
    run_prog(5, 0, 0);
    chk("p4_z", Zflag, 1'b1);
    chk("p4_pc_wrap", pc, 16'd0);
    chk("p4_r5", Ry_data, 16'd0);

    clear_mem();
    mem[0] = enc(1, 0, 0); mem[1] = 16'd7; mem[2] = enc(4'b1010, 0, 0);
    run_prog(2, 0, 0);
    chk("p5_r0", Rx_data, 16'd7);
    chk("p5_z", Zflag, 1'b0);
    chk("p5_pc", pc, 16'd3);
    chk("p5_errs", err_cnt, 1);

    for (int k = 0; k < 4; k++) begin
      fill_rand();
      run_prog(150, -1, 1);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
